// File: rtl/scoreboard_regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry and
// the RiSC-16 write-back source select encoding.
package scoreboard_regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NREGS_DEF  = 8;

  typedef enum logic [1:0] {
    WB_SRC_MEM = 2'd0,
    WB_SRC_ALU = 2'd1,
    WB_SRC_PC1 = 2'd2
  } wb_src_e;

endpackage

// File: rtl/scoreboard_regfile_if.sv
// Bundle of read, write-back and reservation signals of the scoreboarded
// register file; master drives requests, slave is the register file.
interface scoreboard_regfile_if
  import scoreboard_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF
) ();

  localparam int ADDR_W = $clog2(NREGS);

  logic [ADDR_W-1:0] rd0_addr;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;
  logic              rd0_busy;
  logic              rd1_busy;

  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;

  logic [NREGS-1:0]  busy_vec;
  logic [ADDR_W:0]   pend_cnt;
  logic              hazard;

  modport master (
    output rd0_addr, rd1_addr,
    output wa_en, wa_addr, wa_data,
    output wb_en, wb_addr, wb_data,
    output rsv_en, rsv_addr,
    input  rd0_data, rd1_data, rd0_busy, rd1_busy,
    input  busy_vec, pend_cnt, hazard
  );

  modport slave (
    input  rd0_addr, rd1_addr,
    input  wa_en, wa_addr, wa_data,
    input  wb_en, wb_addr, wb_data,
    input  rsv_en, rsv_addr,
    output rd0_data, rd1_data, rd0_busy, rd1_busy,
    output busy_vec, pend_cnt, hazard
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: tracks busy registers, decides which write-backs
// are accepted this cycle and raises a one-cycle hazard for rejected writes.
module regfile_scoreboard
  import scoreboard_regfile_pkg::*;
#(
  parameter  int NREGS  = NREGS_DEF,
  localparam int ADDR_W = $clog2(NREGS),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              wa_ok,
  output logic              wb_ok,
  output logic              rd0_busy,
  output logic              rd1_busy,
  output logic [NREGS-1:0]  busy_vec,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              hazard
);

  logic             wa_live;
  logic             wb_live;
  logic             wa_blocked;
  logic [NREGS-1:0] busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Register 0 and the reset cycle never take part in write-back.
  assign wa_live    = rst_n && wa_en && (wa_addr != '0);
  assign wb_live    = rst_n && wb_en && (wb_addr != '0);
  assign wa_blocked = wa_live && (busy_vec[wa_addr] || (wb_live && (wb_addr == wa_addr)));
  assign wa_ok      = wa_live && !wa_blocked;
  assign wb_ok      = wb_live;

  assign rd0_busy = busy_vec[rd0_addr] && !(wb_live && (wb_addr == rd0_addr));
  assign rd1_busy = busy_vec[rd1_addr] && !(wb_live && (wb_addr == rd1_addr));

  // A same-cycle reservation is applied after the load clear, so it wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (wb_live) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_vec <= '0;
      pend_cnt <= '0;
      hazard   <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      pend_cnt <= cnt_nxt;
      hazard   <= wa_blocked || (wb_live && !busy_vec[wb_addr]);
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Two-read, two-write register file with write-through read bypass and a
// load scoreboard guarding against write-after-write on pending loads.
module scoreboard_regfile
  import scoreboard_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input logic clk,
  input logic rst_n,
  scoreboard_regfile_if.slave bus
);

  logic              wa_ok;
  logic              wb_ok;
  logic [DATA_W-1:0] regs [NREGS];

  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wa_en    (bus.wa_en),
    .wa_addr  (bus.wa_addr),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .rd0_addr (bus.rd0_addr),
    .rd1_addr (bus.rd1_addr),
    .wa_ok    (wa_ok),
    .wb_ok    (wb_ok),
    .rd0_busy (bus.rd0_busy),
    .rd1_busy (bus.rd1_busy),
    .busy_vec (bus.busy_vec),
    .pend_cnt (bus.pend_cnt),
    .hazard   (bus.hazard)
  );

  // Accepted writes never share an address, so their order here is free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wb_ok) begin
        regs[bus.wb_addr] <= bus.wb_data;
      end
      if (wa_ok) begin
        regs[bus.wa_addr] <= bus.wa_data;
      end
    end
  end

  always_comb begin
    bus.rd0_data = regs[bus.rd0_addr];
    if (wa_ok && (bus.wa_addr == bus.rd0_addr)) begin
      bus.rd0_data = bus.wa_data;
    end
    if (wb_ok && (bus.wb_addr == bus.rd0_addr)) begin
      bus.rd0_data = bus.wb_data;
    end
    if (bus.rd0_addr == '0) begin
      bus.rd0_data = '0;
    end
  end

  always_comb begin
    bus.rd1_data = regs[bus.rd1_addr];
    if (wa_ok && (bus.wa_addr == bus.rd1_addr)) begin
      bus.rd1_data = bus.wa_data;
    end
    if (wb_ok && (bus.wb_addr == bus.rd1_addr)) begin
      bus.rd1_data = bus.wb_data;
    end
    if (bus.rd1_addr == '0) begin
      bus.rd1_data = '0;
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Drives one stimulus stream into a 16x8 and a 32x16 register file and
// checks both against a register/busy-set model every cycle.
module tb_scoreboard_regfile;

  logic clk;
  logic rst_n;

  logic        s_wa_en, s_wb_en, s_rsv_en;
  logic [3:0]  s_wa_addr, s_wb_addr, s_rsv_addr, s_rd0_addr, s_rd1_addr;
  logic [31:0] s_wa_data, s_wb_data;

  int vectors;
  int miscompares;
  bit check_en;

  logic [31:0] mregs [2][16];
  bit          mbusy [2][16];
  bit          mhz   [2];

  scoreboard_regfile_if #(.DATA_W(16), .NREGS(8))  ifa ();
  scoreboard_regfile_if #(.DATA_W(32), .NREGS(16)) ifb ();

  assign ifa.wa_en    = s_wa_en;
  assign ifa.wa_addr  = s_wa_addr[2:0];
  assign ifa.wa_data  = s_wa_data[15:0];
  assign ifa.wb_en    = s_wb_en;
  assign ifa.wb_addr  = s_wb_addr[2:0];
  assign ifa.wb_data  = s_wb_data[15:0];
  assign ifa.rsv_en   = s_rsv_en;
  assign ifa.rsv_addr = s_rsv_addr[2:0];
  assign ifa.rd0_addr = s_rd0_addr[2:0];
  assign ifa.rd1_addr = s_rd1_addr[2:0];

  assign ifb.wa_en    = s_wa_en;
  assign ifb.wa_addr  = s_wa_addr;
  assign ifb.wa_data  = s_wa_data;
  assign ifb.wb_en    = s_wb_en;
  assign ifb.wb_addr  = s_wb_addr;
  assign ifb.wb_data  = s_wb_data;
  assign ifb.rsv_en   = s_rsv_en;
  assign ifb.rsv_addr = s_rsv_addr;
  assign ifb.rd0_addr = s_rd0_addr;
  assign ifb.rd1_addr = s_rd1_addr;

  scoreboard_regfile #(.DATA_W(16), .NREGS(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  scoreboard_regfile #(.DATA_W(32), .NREGS(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nr(int d);
    return (d != 0) ? 16 : 8;
  endfunction

  function automatic logic [31:0] dm(int d);
    return (d != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Value a read port must show: newest accepted write this cycle, else storage.
  function automatic logic [31:0] exp_rd(int d, int a);
    int a_wa;
    int a_wb;
    a_wa = int'(s_wa_addr) % nr(d);
    a_wb = int'(s_wb_addr) % nr(d);
    if (a == 0) return 32'h0;
    if (!rst_n) return mregs[d][a];
    if (s_wb_en && a_wb == a) return s_wb_data & dm(d);
    if (s_wa_en && a_wa == a && !mbusy[d][a]) return s_wa_data & dm(d);
    return mregs[d][a];
  endfunction

  function automatic logic exp_rbusy(int d, int a);
    int a_wb;
    a_wb = int'(s_wb_addr) % nr(d);
    if (rst_n && s_wb_en && a_wb == a) return 1'b0;
    return mbusy[d][a];
  endfunction

  function automatic logic [15:0] exp_bv(int d);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < nr(d); i++) v[i] = mbusy[d][i];
    return v;
  endfunction

  function automatic int exp_cnt(int d);
    int c;
    c = 0;
    for (int i = 0; i < nr(d); i++) if (mbusy[d][i]) c++;
    return c;
  endfunction

  function automatic logic [63:0] dut_out(int d, int sel);
    if (d == 0) begin
      case (sel)
        0: return 64'(ifa.rd0_data);
        1: return 64'(ifa.rd1_data);
        2: return 64'(ifa.busy_vec);
        3: return 64'(ifa.pend_cnt);
        4: return 64'(ifa.hazard);
        5: return 64'(ifa.rd0_busy);
        6: return 64'(ifa.rd1_busy);
        default: return 64'h0;
      endcase
    end
    case (sel)
      0: return 64'(ifb.rd0_data);
      1: return 64'(ifb.rd1_data);
      2: return 64'(ifb.busy_vec);
      3: return 64'(ifb.pend_cnt);
      4: return 64'(ifb.hazard);
      5: return 64'(ifb.rd0_busy);
      6: return 64'(ifb.rd1_busy);
      default: return 64'h0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkBoth(input string name, input int sel, input logic [63:0] exp_a, input logic [63:0] exp_b);
    checkOutput({name, "_a"}, dut_out(0, sel), exp_a);
    checkOutput({name, "_b"}, dut_out(1, sel), exp_b);
  endtask

  task automatic applyStimulus(input logic rst, input logic wa, input logic [3:0] waa, input logic [31:0] wad,
                               input logic wb, input logic [3:0] wba, input logic [31:0] wbd,
                               input logic rsv, input logic [3:0] rsa, input logic [3:0] r0, input logic [3:0] r1);
    @(posedge clk);
    #1;
    rst_n = rst;
    s_wa_en = wa;   s_wa_addr = waa;  s_wa_data = wad;
    s_wb_en = wb;   s_wb_addr = wba;  s_wb_data = wbd;
    s_rsv_en = rsv; s_rsv_addr = rsa;
    s_rd0_addr = r0; s_rd1_addr = r1;
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] r0, input logic [3:0] r1);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, r0, r1);
  endtask

  // Reference model advances on every rising edge from the architectural rules.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  a_wa, a_wb, a_rs;
      bit  wa_live, wb_live;
      a_wa = int'(s_wa_addr) % nr(d);
      a_wb = int'(s_wb_addr) % nr(d);
      a_rs = int'(s_rsv_addr) % nr(d);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) begin
          mregs[d][i] = 32'h0;
          mbusy[d][i] = 1'b0;
        end
        mhz[d] = 1'b0;
      end else begin
        wa_live = s_wa_en && a_wa != 0;
        wb_live = s_wb_en && a_wb != 0;
        mhz[d] = (wa_live && (mbusy[d][a_wa] || (wb_live && a_wb == a_wa))) ||
                 (wb_live && !mbusy[d][a_wb]);
        if (wa_live && !mbusy[d][a_wa] && !(wb_live && a_wb == a_wa))
          mregs[d][a_wa] = s_wa_data & dm(d);
        if (wb_live) begin
          mregs[d][a_wb] = s_wb_data & dm(d);
          mbusy[d][a_wb] = 1'b0;
        end
        if (s_rsv_en && a_rs != 0) mbusy[d][a_rs] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < 2; d++) begin
        int a0, a1;
        a0 = int'(s_rd0_addr) % nr(d);
        a1 = int'(s_rd1_addr) % nr(d);
        checkOutput($sformatf("cyc_rd0_data_%0d", d), dut_out(d, 0), 64'(exp_rd(d, a0)));
        checkOutput($sformatf("cyc_rd1_data_%0d", d), dut_out(d, 1), 64'(exp_rd(d, a1)));
        checkOutput($sformatf("cyc_busy_vec_%0d", d), dut_out(d, 2), 64'(exp_bv(d)));
        checkOutput($sformatf("cyc_pend_cnt_%0d", d), dut_out(d, 3), 64'(exp_cnt(d)));
        checkOutput($sformatf("cyc_hazard_%0d", d),   dut_out(d, 4), 64'(mhz[d]));
        checkOutput($sformatf("cyc_rd0_busy_%0d", d), dut_out(d, 5), 64'(exp_rbusy(d, a0)));
        checkOutput($sformatf("cyc_rd1_busy_%0d", d), dut_out(d, 6), 64'(exp_rbusy(d, a1)));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected self-termination");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    check_en = 1'b0;
    rst_n = 1'b0;
    s_wa_en = 1'b0;  s_wa_addr = '0;  s_wa_data = '0;
    s_wb_en = 1'b0;  s_wb_addr = '0;  s_wb_data = '0;
    s_rsv_en = 1'b0; s_rsv_addr = '0;
    s_rd0_addr = 4'd3; s_rd1_addr = 4'd5;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    chkBoth("rst_busy", 2, 0, 0);
    chkBoth("rst_cnt",  3, 0, 0);
    chkBoth("rst_hz",   4, 0, 0);
    chkBoth("rst_rd0",  0, 0, 0);

    // r3 write then read back
    applyStimulus(1, 1, 4'd3, 32'h1234, 0, 0, 0, 0, 0, 4'd3, 4'd0);
    chkBoth("r3_bypass", 0, 'h1234, 'h1234);
    idle(4'd3, 4'd0);
    chkBoth("r3_read", 0, 'h1234, 'h1234);
    chkBoth("r3_hz",   4, 0, 0);

    // both ports hit r5: load port wins, hazard next cycle
    applyStimulus(1, 1, 4'd5, 32'hAAAA, 1, 4'd5, 32'h5555, 0, 0, 4'd0, 4'd5);
    chkBoth("r5_bypass", 1, 'h5555, 'h5555);
    idle(4'd0, 4'd5);
    chkBoth("r5_read", 1, 'h5555, 'h5555);
    chkBoth("r5_hz",   4, 1, 1);
    idle(4'd0, 4'd5);
    chkBoth("r5_hz_end", 4, 0, 0);

    // reservation on r2, blocked ALU write, then load completes
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4'd2, 4'd2, 4'd0);
    chkBoth("rsv_no_bypass", 5, 0, 0);
    idle(4'd2, 4'd0);
    chkBoth("r2_busy_vec", 2, 'h04, 'h04);
    chkBoth("r2_cnt",      3, 1, 1);
    chkBoth("r2_rd_busy",  5, 1, 1);
    applyStimulus(1, 1, 4'd2, 32'h0F0F, 0, 0, 0, 0, 0, 4'd2, 4'd0);
    chkBoth("r2_waw_read", 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 4'd2, 32'hBEEF, 0, 0, 4'd2, 4'd0);
    chkBoth("r2_waw_hz",     4, 1, 1);
    chkBoth("r2_wb_bypass",  0, 'hBEEF, 'hBEEF);
    chkBoth("r2_busy_clear", 5, 0, 0);
    idle(4'd2, 4'd0);
    chkBoth("r2_read",     0, 'hBEEF, 'hBEEF);
    chkBoth("r2_busy_end", 2, 0, 0);
    chkBoth("r2_cnt_end",  3, 0, 0);
    chkBoth("r2_hz_end",   4, 0, 0);

    // register 0 is immutable
    applyStimulus(1, 1, 4'd0, 32'hFFFF, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0);
    chkBoth("r0_bypass", 0, 0, 0);
    idle(4'd0, 4'd0);
    chkBoth("r0_read", 0, 0, 0);
    chkBoth("r0_busy", 2, 0, 0);
    chkBoth("r0_hz",   4, 0, 0);

    // reset drops pending loads and ignores same-cycle writes
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4'd4, 4'd4, 4'd6);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4'd6, 4'd4, 4'd6);
    idle(4'd4, 4'd6);
    chkBoth("r46_busy", 2, 'h50, 'h50);
    chkBoth("r46_cnt",  3, 2, 2);
    applyStimulus(0, 1, 4'd3, 32'h7777, 0, 0, 0, 1, 4'd5, 4'd3, 4'd6);
    chkBoth("rst_cycle_busy", 2, 'h50, 'h50);
    chkBoth("rst_cycle_rd3",  0, 'h1234, 'h1234);
    idle(4'd4, 4'd3);
    chkBoth("post_rst_busy", 2, 0, 0);
    chkBoth("post_rst_cnt",  3, 0, 0);
    chkBoth("post_rst_rd4",  0, 0, 0);
    chkBoth("post_rst_rd3",  1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 4'd4, 32'h0001, 0, 0, 4'd4, 4'd0);
    chkBoth("r4_bypass", 0, 1, 1);
    idle(4'd4, 4'd0);
    chkBoth("r4_read", 0, 1, 1);
    chkBoth("r4_hz",   4, 1, 1);

    // top register (r15 on the wide file, r7 on the narrow one)
    applyStimulus(1, 1, 4'd15, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4'd15, 4'd0);
    idle(4'd15, 4'd0);
    chkBoth("r15_read", 0, 'hBEEF, 'hDEADBEEF);
    checkOutput("model_r7_a",  64'(mregs[0][7]),  64'h0000BEEF);
    checkOutput("model_r15_b", 64'(mregs[1][15]), 64'hDEADBEEF);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 4'd15, 4'd15, 4'd15);
    idle(4'd15, 4'd15);
    chkBoth("r15_busy_vec", 2, 'h80, 'h8000);
    chkBoth("r15_cnt",      3, 1, 1);
    chkBoth("r15_rd_busy",  6, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 4'd15, 32'hCAFEF00D, 1, 4'd15, 4'd15, 4'd0);
    chkBoth("r15_wb_bypass", 0, 'hF00D, 'hCAFEF00D);
    idle(4'd15, 4'd0);
    chkBoth("r15_rsv_wins", 2, 'h80, 'h8000);
    chkBoth("r15_wb_read",  0, 'hF00D, 'hCAFEF00D);
    chkBoth("r15_wb_hz",    4, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 4'd15, 32'h0BADCAFE, 0, 0, 4'd15, 4'd0);
    idle(4'd15, 4'd0);
    chkBoth("r15_final_busy", 2, 0, 0);
    chkBoth("r15_final_read", 0, 'hCAFE, 'h0BADCAFE);
    idle(4'd0, 4'd0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 The block SHALL have parameter NREGS, default 8, meaning register count (power of two, >=2); ADDR_W = $clog2(NREGS).
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have ports rd0_addr, rd1_addr  in  ADDR_W  read-port addresses.
REQ-006 The block SHALL have ports rd0_data, rd1_data  out  DATA_W  read data, combinational.
REQ-007 The block SHALL have ports rd0_busy, rd1_busy  out  1  addressed register has a pending load.
REQ-008 The block SHALL have ports wa_en 1, wa_addr ADDR_W, wa_data DATA_W, all in  ALU/PC write-back port.
REQ-009 The block SHALL have ports wb_en 1, wb_addr ADDR_W, wb_data DATA_W, all in  memory (load) write-back port.
REQ-010 The block SHALL have ports rsv_en 1, rsv_addr ADDR_W, both in  reserve register at load issue.
REQ-011 The block SHALL have port busy_vec  out  NREGS  per-register pending bits (registered).
REQ-012 The block SHALL have port pend_cnt  out  ADDR_W+1  number of set busy bits (registered).
REQ-013 The block SHALL have port hazard  out  1  one-cycle registered pulse flagging a rejected write.

Function
REQ-014 Register 0 SHALL read as zero on both ports, SHALL ignore writes and reservations, and busy_vec[0] SHALL be 0 always.
REQ-015 Reads SHALL bypass: same-cycle accepted write to the read address returns the write data; port B data wins if both ports write that address.
REQ-016 Writes SHALL commit at the rising clk edge; port B commits over port A on address collision, port A write dropped and hazard pulsed next cycle.
REQ-017 rsv_en with rsv_addr!=0 SHALL set busy[rsv_addr] at the clock edge.
REQ-018 wb_en SHALL write wb_data and clear busy[wb_addr] at the clock edge.
REQ-019 rsv and wb to the same address in one cycle SHALL write the data and leave busy set (new reservation wins).
REQ-020 wa_en to a register whose busy bit is set SHALL be suppressed (WAW protection) and pulse hazard next cycle; busy unchanged.
REQ-021 wb_en to a non-busy register SHALL still write data, leave busy 0, and pulse hazard next cycle.
REQ-022 rsv_en to an already-busy register SHALL keep it busy, no hazard.
REQ-023 rd*_busy SHALL reflect busy_vec after same-cycle wb clear but not same-cycle rsv set (i.e. combinational clear-bypass only).
REQ-024 pend_cnt SHALL equal popcount of busy_vec each cycle, range 0..NREGS-1.

Reset
REQ-025 With rst_n=0 at a clk edge, all registers SHALL become 0, busy_vec 0, pend_cnt 0, hazard 0; writes and reservations that cycle SHALL be ignored.
REQ-026 Reset asserted mid-load SHALL drop the pending reservation; a later wb_en to that register SHALL write data and pulse hazard.
REQ-027 Read ports SHALL remain combinational during reset, returning the reset-cleared contents after the edge.

Structure
REQ-028 The shared package SHALL hold default DATA_W/NREGS constants and the RiSC-16 write-back source select encoding (MEM=0, ALU=1, PC+1=2).
REQ-029 One sub-module, regfile_scoreboard, SHALL hold busy_vec, pend_cnt and hazard logic; storage and bypass SHALL stay in the top.

Verification
REQ-030 Reset, then wa_en r3=0x1234; next cycle rd0_addr=3 -> rd0_data=0x1234, hazard=0.
REQ-031 Same cycle wa_en r5=0xAAAA and wb_en r5=0x5555, rd1_addr=5 -> rd1_data=0x5555 combinationally; r5=0x5555 after edge; hazard=1 for one cycle.
REQ-032 rsv_en r2 -> busy_vec=0x04, pend_cnt=1; wa_en r2=0x0F0F -> r2 unchanged, hazard pulse; wb_en r2=0xBEEF -> r2=0xBEEF, busy_vec=0x00, pend_cnt=0.
REQ-033 wa_en r0=0xFFFF, rsv_en r0 -> rd0_addr=0 returns 0x0000, busy_vec=0x00.
REQ-034 rsv_en r4, r6 on consecutive cycles, then rst_n=0 one cycle -> busy_vec=0, pend_cnt=0, all reads 0; wb_en r4=0x0001 -> r4=0x0001, hazard pulse.
REQ-035 Repeat REQ-030..REQ-034 with DATA_W=32, NREGS=16, also covering r15 and a 0xDEADBEEF write.
